axi_lite_responder: RTL and testbench

AXI_LITE_RESPONDER -- requirements
Module: axi_lite_responder

---
 rtl/axi_lite_responder_if.sv | 39 +++
 rtl/axi_lite_responder.sv | 177 +++++++++++++++++
 tb/tb_axi_lite_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_responder_if.sv
// AXI4-Lite bundle between a bus master and axi_lite_responder.
// The slave modport is the responder's view and the master modport is the initiator's view.
interface axi_lite_responder_if;
   logic [31:0] s_axi_araddr;
   logic [2:0]  s_axi_arsize;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] s_axi_awaddr;
   logic [2:0]  s_axi_awsize;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;

   modport slave (
      input  s_axi_araddr, s_axi_arsize, s_axi_arvalid, s_axi_rready,
      input  s_axi_awaddr, s_axi_awsize, s_axi_awvalid,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
   );

   modport master (
      output s_axi_araddr, s_axi_arsize, s_axi_arvalid, s_axi_rready,
      output s_axi_awaddr, s_axi_awsize, s_axi_awvalid,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
   );
endinterface

// File: rtl/axi_lite_responder.sv
// AXI4-Lite register-file responder: DEPTH x 32-bit words with byte-strobed writes and a 1-cycle read.
// Define AXI_RESP_RANGE_CHECK_EN to answer out-of-window accesses with SLVERR instead of aliasing them.
module axi_lite_responder #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                s_areset,
   axi_lite_responder_if.slave s_axi
);
   localparam int unsigned IDX_W       = $clog2(DEPTH);
   localparam logic [31:0] SPAN        = 32'(DEPTH) << 2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   logic [31:0]      r_mem [DEPTH];

   logic             r_out_en;
   rd_state_t        r_rstate;
   rd_state_t        w_rstate_next;
   logic             w_arready;
   logic             w_rvalid;
   logic             w_ar_fire;
   logic [31:0]      r_rdata;
   logic [1:0]       r_rresp;

   logic [31:0]      w_ar_off;
   logic [31:0]      w_aw_off;
   logic [IDX_W-1:0] w_ar_idx;
   logic [IDX_W-1:0] w_aw_idx;
   logic             w_ar_ok;
   logic             w_aw_ok;

   logic             r_aw_held;
   logic [IDX_W-1:0] r_aw_idx;
   logic             r_aw_ok;
   logic             r_w_held;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_bvalid;
   logic [1:0]       r_bresp;

   logic             w_awready;
   logic             w_wready;
   logic             w_aw_fire;
   logic             w_w_fire;
   logic             w_b_fire;
   logic             w_commit;
   logic [IDX_W-1:0] w_c_idx;
   logic             w_c_ok;
   logic [31:0]      w_c_data;
   logic [3:0]       w_c_strb;
   logic [3:0]       w_lane_we;
   logic             w_unused;

   // Offsets from the window base; the low word-index bits alias modulo DEPTH.
   assign w_ar_off = s_axi.s_axi_araddr - BASE_ADDR;
   assign w_aw_off = s_axi.s_axi_awaddr - BASE_ADDR;
   assign w_ar_idx = w_ar_off[IDX_W+1:2];
   assign w_aw_idx = w_aw_off[IDX_W+1:2];

`ifdef AXI_RESP_RANGE_CHECK_EN
   assign w_ar_ok = (w_ar_off < SPAN);
   assign w_aw_ok = (w_aw_off < SPAN);
`else
   assign w_ar_ok = 1'b1;
   assign w_aw_ok = 1'b1;
`endif

   assign w_unused = ^{s_axi.s_axi_arsize, s_axi.s_axi_awsize, w_ar_off, w_aw_off, SPAN};

   always_comb begin
      w_rstate_next = r_rstate;
      w_arready     = 1'b0;
      w_rvalid      = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_arready = r_out_en;
            if (r_out_en && s_axi.s_axi_arvalid) begin
               w_rstate_next = R_DATA;
            end
         end
         R_DATA: begin
            w_rvalid = 1'b1;
            if (s_axi.s_axi_rready) begin
               w_rstate_next = R_IDLE;
            end
         end
         default: w_rstate_next = R_IDLE;
      endcase
   end

   assign w_ar_fire = w_arready & s_axi.s_axi_arvalid;

   always_ff @(posedge clk) begin
      if (s_areset) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         r_rstate <= w_rstate_next;
         if (w_ar_fire) begin
            r_rdata <= w_ar_ok ? r_mem[w_ar_idx] : '0;
            r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign w_awready = r_out_en & ~r_aw_held & ~r_bvalid;
   assign w_wready  = r_out_en & ~r_w_held & ~r_bvalid;
   assign w_aw_fire = w_awready & s_axi.s_axi_awvalid;
   assign w_w_fire  = w_wready & s_axi.s_axi_wvalid;
   assign w_b_fire  = r_bvalid & s_axi.s_axi_bready;

   // The write lands on the edge that completes the AW/W pair, sourcing each half from the bus or its holding register.
   assign w_commit = ~s_areset & ~r_bvalid & (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
   assign w_c_idx  = r_aw_held ? r_aw_idx : w_aw_idx;
   assign w_c_ok   = r_aw_held ? r_aw_ok  : w_aw_ok;
   assign w_c_data = r_w_held  ? r_wdata  : s_axi.s_axi_wdata;
   assign w_c_strb = r_w_held  ? r_wstrb  : s_axi.s_axi_wstrb;

   always_ff @(posedge clk) begin
      if (s_areset) begin
         r_out_en  <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_out_en <= 1'b1;
         if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_ok   <= w_aw_ok;
         end
         if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.s_axi_wdata;
            r_wstrb  <= s_axi.s_axi_wstrb;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_c_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (w_b_fire) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
         assign w_lane_we[gi] = w_commit & w_c_ok & w_c_strb[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (w_lane_we[b]) begin
            r_mem[w_c_idx][8*b +: 8] <= w_c_data[8*b +: 8];
         end
      end
   end

   assign s_axi.s_axi_arready = w_arready;
   assign s_axi.s_axi_rvalid  = w_rvalid;
   assign s_axi.s_axi_rdata   = r_rdata;
   assign s_axi.s_axi_rresp   = r_rresp;
   assign s_axi.s_axi_awready = w_awready;
   assign s_axi.s_axi_wready  = w_wready;
   assign s_axi.s_axi_bvalid  = r_bvalid;
   assign s_axi.s_axi_bresp   = r_bresp;
endmodule

// File: tb/tb_axi_lite_responder.sv
// Randomised self-checking bench for axi_lite_responder against a word-array reference model.
// Directed sequences exercise reset behaviour, strobes, channel ordering, backpressure and address windowing.
module tb_axi_lite_responder;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk  = 1'b0;
   logic srst = 1'b1;
   always #5 clk = ~clk;

   axi_lite_responder_if bus();

   axi_lite_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk      (clk),
      .s_areset (srst),
      .s_axi    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] model_mem [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_in_range(input logic [31:0] a);
`ifdef AXI_RESP_RANGE_CHECK_EN
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
`else
      return 1'b1;
`endif
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off / 4) % DEPTH);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!model_in_range(a)) return 32'h0;
      return model_mem[model_idx(a)];
   endfunction

   function automatic logic [1:0] model_resp(input logic [31:0] a);
      return model_in_range(a) ? 2'b00 : 2'b10;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (model_in_range(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[model_idx(a)][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done;
      bit w_done;
      aw_done = 1'b0;
      w_done  = 1'b0;
      fork
         begin
            repeat (aw_dly) tick();
            bus.s_axi_awaddr  = addr;
            bus.s_axi_awsize  = 3'd2;
            bus.s_axi_awvalid = 1'b1;
            for (int t = 0; t < 50 && !aw_done; t++) begin
               if (bus.s_axi_awready) aw_done = 1'b1;
               tick();
            end
            bus.s_axi_awvalid = 1'b0;
            if (!w_done) check("b_early_aw_only", 32'(bus.s_axi_bvalid), 32'd0);
         end
         begin
            repeat (w_dly) tick();
            bus.s_axi_wdata  = data;
            bus.s_axi_wstrb  = strb;
            bus.s_axi_wvalid = 1'b1;
            for (int t = 0; t < 50 && !w_done; t++) begin
               if (bus.s_axi_wready) w_done = 1'b1;
               tick();
            end
            bus.s_axi_wvalid = 1'b0;
            if (!aw_done) check("b_early_w_only", 32'(bus.s_axi_bvalid), 32'd0);
         end
      join
      check("aw_handshake", 32'(aw_done), 32'd1);
      check("w_handshake", 32'(w_done), 32'd1);
      check("b_valid_latency", 32'(bus.s_axi_bvalid), 32'd1);
      check("b_resp", 32'(bus.s_axi_bresp), 32'(model_resp(addr)));
      model_write(addr, data, strb);
      for (int i = 0; i < b_dly; i++) begin
         tick();
         check("b_valid_hold", 32'(bus.s_axi_bvalid), 32'd1);
         check("aw_ready_blocked", 32'(bus.s_axi_awready), 32'd0);
      end
      bus.s_axi_bready = 1'b1;
      tick();
      bus.s_axi_bready = 1'b0;
      check("b_valid_clear", 32'(bus.s_axi_bvalid), 32'd0);
      check("aw_ready_after_b", 32'(bus.s_axi_awready), 32'd1);
      check("w_ready_after_b", 32'(bus.s_axi_wready), 32'd1);
      $display("WR addr=%08h data=%08h strb=%h aw_dly=%0d w_dly=%0d b_dly=%0d", addr, data, strb, aw_dly, w_dly, b_dly);
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_dly);
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      bit          done;
      exp_data = model_read(addr);
      exp_resp = model_resp(addr);
      done     = 1'b0;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arsize  = 3'd2;
      bus.s_axi_arvalid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         if (bus.s_axi_arready) done = 1'b1;
         tick();
      end
      bus.s_axi_arvalid = 1'b0;
      check("ar_handshake", 32'(done), 32'd1);
      check("r_valid_latency", 32'(bus.s_axi_rvalid), 32'd1);
      check("r_data", bus.s_axi_rdata, exp_data);
      check("r_resp", 32'(bus.s_axi_rresp), 32'(exp_resp));
      check("ar_ready_busy", 32'(bus.s_axi_arready), 32'd0);
      for (int i = 0; i < r_dly; i++) begin
         tick();
         check("r_valid_hold", 32'(bus.s_axi_rvalid), 32'd1);
         check("r_data_hold", bus.s_axi_rdata, exp_data);
         check("ar_ready_hold", 32'(bus.s_axi_arready), 32'd0);
      end
      bus.s_axi_rready = 1'b1;
      tick();
      bus.s_axi_rready = 1'b0;
      check("r_valid_clear", 32'(bus.s_axi_rvalid), 32'd0);
      check("ar_ready_after_r", 32'(bus.s_axi_arready), 32'd1);
      $display("RD addr=%08h exp_data=%08h exp_resp=%0d r_dly=%0d", addr, exp_data, exp_resp, r_dly);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      bus.s_axi_araddr  = '0;
      bus.s_axi_arsize  = '0;
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready  = 1'b0;
      bus.s_axi_awaddr  = '0;
      bus.s_axi_awsize  = '0;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata   = '0;
      bus.s_axi_wstrb   = '0;
      bus.s_axi_wvalid  = 1'b0;
      bus.s_axi_bready  = 1'b0;

      srst = 1'b1;
      repeat (3) tick();
      check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
      check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
      check("rst_wready", 32'(bus.s_axi_wready), 32'd0);
      check("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
      check("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
      check("rst_rdata", bus.s_axi_rdata, 32'd0);
      check("rst_rresp", 32'(bus.s_axi_rresp), 32'd0);
      check("rst_bresp", 32'(bus.s_axi_bresp), 32'd0);
      srst = 1'b0;
      tick();
      check("rel_arready", 32'(bus.s_axi_arready), 32'd1);
      check("rel_awready", 32'(bus.s_axi_awready), 32'd1);
      check("rel_wready", 32'(bus.s_axi_wready), 32'd1);

      // Storage is not reset, so give every word a known value first.
      for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

      // AW and W together, then read back.
      do_write(BASE + 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_read(BASE + 32'h04, 0);
      check("deadbeef_const", model_read(BASE + 32'h04), 32'hDEADBEEF);

      // W three cycles ahead of AW, partial strobe over a zeroed word.
      do_write(BASE + 32'h08, 32'h0, 4'hF, 0, 0, 0);
      do_write(BASE + 32'h08, 32'h11223344, 4'h5, 3, 0, 0);
      do_read(BASE + 32'h08, 0);
      check("strobe_merge_const", model_read(BASE + 32'h08), 32'h00220044);

      // Zero strobe completes without changing storage.
      do_write(BASE + 32'h0C, 32'hFFFFFFFF, 4'h0, 1, 2, 1);
      do_read(BASE + 32'h0C, 0);

      // Read backpressure for five cycles, then an immediate second read.
      do_read(BASE + 32'h04, 5);
      do_read(BASE + 32'h08, 0);

      // Read and write to the same word resolved on the same edge: the read sees the old data.
      fork
         do_write(BASE + 32'h10, 32'hA5A5_5A5A, 4'hF, 0, 0, 1);
         do_read(BASE + 32'h10, 1);
      join
      do_read(BASE + 32'h10, 0);

      // Reset while a response waits for bready.
      bus.s_axi_awaddr  = BASE + 32'h14;
      bus.s_axi_wdata   = 32'h0BAD_F00D;
      bus.s_axi_wstrb   = 4'hF;
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wvalid  = 1'b1;
      tick();
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      check("pre_rst_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
      model_write(BASE + 32'h14, 32'h0BAD_F00D, 4'hF);
      srst = 1'b1;
      tick();
      check("midrst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
      check("midrst_awready", 32'(bus.s_axi_awready), 32'd0);
      check("midrst_wready", 32'(bus.s_axi_wready), 32'd0);
      srst = 1'b0;
      tick();
      check("midrel_awready", 32'(bus.s_axi_awready), 32'd1);
      check("midrel_wready", 32'(bus.s_axi_wready), 32'd1);
      $display("WR addr=%08h data=%08h strb=f interrupted by reset", BASE + 32'h14, 32'h0BAD_F00D);
      do_read(BASE + 32'h14, 0);

      // A held AW is discarded by reset; a later W alone must not commit.
      bus.s_axi_awaddr  = BASE + 32'h18;
      bus.s_axi_awvalid = 1'b1;
      tick();
      bus.s_axi_awvalid = 1'b0;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      tick();
      bus.s_axi_wdata  = 32'h1357_9BDF;
      bus.s_axi_wstrb  = 4'hF;
      bus.s_axi_wvalid = 1'b1;
      tick();
      bus.s_axi_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("no_commit_without_aw", 32'(bus.s_axi_bvalid), 32'd0);
         tick();
      end
      bus.s_axi_awaddr  = BASE + 32'h1C;
      bus.s_axi_awvalid = 1'b1;
      tick();
      bus.s_axi_awvalid = 1'b0;
      check("late_aw_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
      model_write(BASE + 32'h1C, 32'h1357_9BDF, 4'hF);
      bus.s_axi_bready = 1'b1;
      tick();
      bus.s_axi_bready = 1'b0;
      $display("WR addr=%08h data=%08h strb=f after discarded AW", BASE + 32'h1C, 32'h1357_9BDF);
      do_read(BASE + 32'h18, 0);
      do_read(BASE + 32'h1C, 0);

      // Addresses past the window: SLVERR with the range check, aliasing without it.
      do_read(BASE + 32'h40, 0);
`ifdef AXI_RESP_RANGE_CHECK_EN
      check("oob_rdata_const", model_read(BASE + 32'h40), 32'h0);
`else
      check("alias_rdata_word0", model_read(BASE + 32'h40), model_mem[0]);
`endif
      do_write(BASE + 32'h44, 32'h7777_8888, 4'hF, 0, 1, 0);
      do_read(BASE + 32'h04, 0);

      for (int n = 0; n < 60; n++) begin
         a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
         d = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         end else begin
            do_read(a, $urandom_range(0, 3));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
